// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: opcodes, FSM states,
// and the classifier that separates one-cycle ops from iterative ones.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_t;

  function automatic logic is_multicycle(alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIVU) ||
           (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of shift-add multiply or restoring unsigned divide.
// Ports: op selects mul vs div; acc is the running sum/remainder,
// in_bit the multiplier LSB or next dividend bit, operand the
// shifted multiplicand or divisor; acc_next/q_bit are the results.
module alu_muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] acc,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted  = {acc, in_bit};
    trial    = shifted - {1'b0, operand};
    acc_next = acc;
    q_bit    = 1'b0;
    if (op != OP_MUL) begin
      // Remainder is always below the divisor, so the shifted
      // value needs one extra bit before the trial subtract.
      // A zero divisor always subtracts: quotient all-ones,
      // remainder ends up equal to the dividend.
      if (shifted >= {1'b0, operand}) begin
        acc_next = trial[WIDTH-1:0];
        q_bit    = 1'b1;
      end else begin
        acc_next = shifted[WIDTH-1:0];
      end
    end else if (in_bit) begin
      acc_next = acc + operand;
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// Handshaked execute-stage ALU: one-cycle logic/arith/shift ops,
// WIDTH-cycle iterative mul/divu/remu. Ports: clk, reset (async
// high), in_valid/in_ready + SrcA/SrcB/ALUControl request side,
// out_valid/out_ready + ALUResult/zero response side, busy.
module alu_iterative
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             busy
);

  alu_state_t       state;
  alu_state_t       state_n;
  alu_op_t          op_in;
  alu_op_t          op_q;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] step_operand;
  logic [SHW-1:0]   shamt;
  logic             in_bit;
  logic             q_bit;
  logic             last;

  assign op_in     = alu_op_t'(ALUControl);
  assign shamt     = SrcB[SHW-1:0];
  assign last      = (cnt == (SHW+1)'(1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign ALUResult = res_q;
  assign zero      = (res_q == '0);

  always_comb begin
    single_res = '0;
    case (op_in)
      OP_ADD:  single_res = SrcA + SrcB;
      OP_SUB:  single_res = SrcA - SrcB;
      OP_AND:  single_res = SrcA & SrcB;
      OP_OR:   single_res = SrcA | SrcB;
      OP_XOR:  single_res = SrcA ^ SrcB;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}},
                 $signed(SrcA) < $signed(SrcB)};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}},
                 SrcA < SrcB};
      OP_SLL:  single_res = SrcA << shamt;
      OP_SRL:  single_res = SrcA >> shamt;
      OP_SRA:  single_res =
                 $unsigned($signed(SrcA) >>> shamt);
      default: single_res = '0;
    endcase
  end

  // Mul walks the multiplier LSB-first against a left-shifting
  // multiplicand; div feeds dividend bits MSB-first while the
  // quotient shifts into the vacated low end of a_q.
  always_comb begin
    in_bit       = a_q[WIDTH-1];
    step_operand = b_q;
    if (op_q == OP_MUL) begin
      in_bit       = b_q[0];
      step_operand = a_q;
    end
  end

  alu_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .in_bit  (in_bit),
    .operand (step_operand),
    .acc_next(acc_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid)
              state_n = is_multicycle(op_in) ? BUSY : DONE;
      BUSY: if (last)      state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= OP_ADD;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (is_multicycle(op_in)) begin
            op_q  <= op_in;
            a_q   <= SrcA;
            b_q   <= SrcB;
            acc_q <= '0;
            cnt   <= (SHW+1)'(WIDTH);
          end else begin
            res_q <= single_res;
          end
        end
        BUSY: begin
          cnt   <= cnt - 1'b1;
          acc_q <= acc_next;
          if (op_q == OP_MUL) begin
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end else begin
            a_q <= {a_q[WIDTH-2:0], q_bit};
          end
          if (last) begin
            if (op_q == OP_DIVU)
              res_q <= {a_q[WIDTH-2:0], q_bit};
            else
              res_q <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative (WIDTH=32): directed vectors,
// expected results queued at accept, checked by a separate monitor.
module tb_alu_iterative;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [3:0]  ALUControl = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] ALUResult;
  logic        zero;
  logic        busy;

  int   checks = 0;
  int   fails = 0;
  exp_t exp_q[$];

  alu_iterative #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUControl(ALUControl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got 0x%08h expected none",
                 ALUResult);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, " result"}, ALUResult, e.val);
        chk({e.name, " zero"}, 32'(zero), 32'(e.val == 0));
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready wait", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e,
                        input int lat, input string name);
    int n;
    bit busy_ok;
    exp_t x;
    wait_ready();
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    @(posedge clk);
    x.val  = e;
    x.name = name;
    exp_q.push_back(x);
    #1;
    in_valid = 1'b0;
    SrcA     = 32'hDEADBEEF;
    SrcB     = 32'h0BADF00D;
    n        = 1;
    busy_ok  = 1'b1;
    while (!out_valid && n < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    if (lat > 1) chk({name, " busy"}, 32'(busy_ok), 32'd1);
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst ALUResult", ALUResult, 32'h0);
    chk("rst zero", 32'(zero), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_op(4'b0011, 32'hF0, 32'h0F, 32'hFF, 1, "or");

    // Abandon a multiply with an asynchronous reset.
    wait_ready();
    in_valid   = 1'b1;
    ALUControl = 4'b1010;
    SrcA       = 32'd3;
    SrcB       = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mul busy pre-reset", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst ALUResult", ALUResult, 32'h0);
    chk("arst zero", 32'(zero), 32'd1);
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    run_op(4'b0000, 32'd5, 32'd7, 32'd12, 1, "add");
    run_op(4'b0001, 32'h10, 32'h10, 32'h0, 1, "sub");
    run_op(4'b0101, 32'hFFFFFFFF, 32'd1, 32'd1, 1, "slt");
    run_op(4'b0110, 32'hFFFFFFFF, 32'd1, 32'd0, 1, "sltu");
    run_op(4'b1001, 32'h80000000, 32'h24, 32'hF8000000, 1, "sra");
    run_op(4'b1000, 32'h80000000, 32'h24, 32'h08000000, 1, "srl");
    run_op(4'b0111, 32'h1, 32'h3F, 32'h80000000, 1, "sll");
    run_op(4'b0100, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1, "xor");
    run_op(4'b0010, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1, "and");
    run_op(4'b1101, 32'h12, 32'h34, 32'h0, 1, "op1101");
    run_op(4'b1111, 32'h12, 32'h34, 32'h0, 1, "op1111");
    run_op(4'b1010, 32'h00012345, 32'h00010000, 32'h23450000, 33, "mul");
    run_op(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33, "mul_neg");
    run_op(4'b1011, 32'd100, 32'd7, 32'd14, 33, "divu");
    run_op(4'b1100, 32'd100, 32'd7, 32'd2, 33, "remu");
    run_op(4'b1011, 32'h1234, 32'd0, 32'hFFFFFFFF, 33, "divu_by0");
    run_op(4'b1100, 32'd9, 32'd0, 32'd9, 33, "remu_by0");
    run_op(4'b1011, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, "divu_big");

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    run_op(4'b0000, 32'd3, 32'd4, 32'd7, 1, "add_bp");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid   = 1'b1;
        ALUControl = 4'b0001;
        SrcA       = 32'd9;
        SrcB       = 32'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bp hold result", ALUResult, 32'd7);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    run_op(4'b0100, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1, "xor_after_bp");

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Parametrised, handshaked successor to the datapath's single-cycle combinational ALU.
- Retains that ALU's add/sub/and/or/slt opcode encodings, widened to a 4-bit control field.
- Adds xor, sltu and shifts, plus iterative multiply and unsigned divide/remainder executed one bit per cycle.
- Sits in the execute stage; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept an operation.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B; low SHW bits are the shift amount.
- ALUControl  input  4  operation code (see Behaviour).
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer accepts result.
- ALUResult  output  WIDTH  registered result.
- zero  output  1  ALUResult == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu.
  - 0111 sll, 1000 srl, 1001 sra.
  - 1010 mul (low WIDTH bits of product), 1011 divu, 1100 remu.
  - 1101-1111 produce result 0 with single-cycle timing.
- Arithmetic: add/sub wrap modulo 2^WIDTH. slt/sltu yield 1 or 0, zero-extended. Shifts use SrcB[SHW-1:0] only; sra replicates SrcA[WIDTH-1].
- Reset: state=IDLE, ALUResult=0, zero=1, out_valid=0, busy=0, counter=0, in_ready=1. Reset mid-operation abandons the op with no output.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1. Accept when in_valid.
  - Single-cycle op: result registered at the accept edge; next state DONE.
  - mul/divu/remu: latch operands, counter=WIDTH; next state BUSY.
- BUSY:
  - in_ready=0. One iteration per cycle; counter decrements.
  - mul: shift-add on the multiplier LSB.
  - divu/remu: restoring division, one quotient bit per cycle.
  - At counter==1 the final iteration writes ALUResult; next state DONE.
- DONE:
  - out_valid=1; ALUResult and zero are stable.
  - On out_ready go to IDLE. Without out_ready, hold indefinitely.
  - in_ready=0, so there is no accept in the same cycle as a result handoff.
- Latency from accept edge to out_valid high:
  - single-cycle ops: 1 cycle.
  - mul/div: WIDTH+1 cycles.
- Throughput: at most one op per 2 cycles (single-cycle ops).
- Divide by zero (RISC-V semantics): divu returns all-ones, remu returns SrcA. It still takes WIDTH+1 cycles, keeping timing data-independent.
- Operand inputs are don't-care after the accept edge; the block uses only latched copies.
- zero is derived from the registered ALUResult, never from combinational inputs.
- in_valid while not IDLE is ignored and not queued; the producer must hold it until in_ready.

Decomposition:
- Shared package alu_pkg:
  - enum alu_op_t for the 4-bit opcodes.
  - enum alu_state_t {IDLE, BUSY, DONE}.
  - function is_multicycle(alu_op_t).
- One sub-module: alu_muldiv_step, a combinational single-iteration datapath. It takes mode, partial accumulator/remainder, and shifted operand, and returns the next accumulator and quotient bit. The top instantiates it once, driven by the counter FSM.

Test Plan (WIDTH=32):
- Reset asserted while BUSY on a mul -> outputs return to reset values asynchronously. After release, add 5+7 -> ALUResult=12, zero=0, out_valid exactly 1 cycle after accept.
- sub 0x10-0x10 -> ALUResult=0, zero=1. slt 0xFFFFFFFF,1 -> 1. sltu 0xFFFFFFFF,1 -> 0.
- sra 0x80000000 by SrcB=0x24 (amount 4) -> 0xF8000000. srl of the same -> 0x08000000.
- mul 0x00012345 * 0x00010000 -> 0x23450000. out_valid rises exactly 33 cycles after accept; busy=1 throughout.
- divu 100/7 -> 14 and remu -> 2. divu x/0 -> 0xFFFFFFFF and remu 9/0 -> 9, each in 33 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> ALUResult stable, in_ready=0, and a pulsed in_valid is ignored. Raise out_ready -> IDLE next cycle, then a new op is accepted.
